mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 256-bit line-memory port between two set-associative cache clients
//  (e.g. I-cache = client 0, D-cache = client 1).
//  Cache mem requests are single-cycle pulses with no back-pressure, so each client
//  gets a small request FIFO. Round-robin arbitration issues one transaction at a time
//  downstream and routes read responses back to the owning client.
// PARAMETERS
//  ADDR_W   15   line (block) address width
//  LINE_W   256  line data width
//  QDEPTH   2    per-client request FIFO depth, power of 2, >=2 (writeback+fetch pair)
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       asynchronous, active-low reset
//  cN_req_valid   in   1       client N request pulse (N=0,1), one per cycle max
//  cN_req_rw      in   1       1=write (writeback), 0=read (line fill)
//  cN_req_addr    in   ADDR_W  client N line address
//  cN_req_wdata   in   LINE_W  client N write line
//  cN_resp_valid  out  1       client N read-response pulse
//  cN_resp_rdata  out  LINE_W  client N read line
//  cN_overflow    out  1       sticky: client N request dropped (FIFO full)
//  m_req_valid    out  1       downstream request valid
//  m_req_ready    in   1       downstream accepts request
//  m_req_rw       out  1       downstream request type
//  m_req_addr     out  ADDR_W  downstream line address
//  m_req_wdata    out  LINE_W  downstream write line
//  m_resp_valid   in   1       downstream read data valid (reads only)
//  m_resp_rdata   in   LINE_W  downstream read line
// BEHAVIOUR
//  Reset (async): all outputs 0, FIFOs empty, state IDLE, rr pointer = client 0, overflow flags 0.
//  Enqueue:
//   - cN_req_valid captured at posedge into FIFO N.
//   - Push while full: request dropped, cN_overflow<=1 (cleared only by reset).
//   - Push and pop in the same cycle allowed, incl. when full.
//  FSM IDLE:
//   - If any FIFO is non-empty, grant: if both non-empty, the client != last_grant wins; else the non-empty one.
//   - Pop head into issue register, last_grant<=winner, go ISSUE.
//   - Both empty: stay IDLE.
//  FSM ISSUE:
//   - m_req_valid=1, rw/addr/wdata stable from issue register until m_req_ready.
//   - Handshake with rw=1: go IDLE, no response.
//   - Handshake with rw=0: go WAIT_RESP.
//  FSM WAIT_RESP:
//   - On m_resp_valid: next cycle cN_resp_valid=1 for the owner (1 cycle), cN_resp_rdata=m_resp_rdata; go IDLE.
//   - The other client's resp_valid stays 0.
//  Ordering and latency:
//   - Strict FIFO order per client: a writeback always precedes its fetch.
//   - At most one downstream transaction outstanding.
//   - Push at edge N, FIFO idle, FSM IDLE: m_req_valid high from edge N+2.
//   - Read resp at edge M: client resp_valid high from edge M+1.
//  Boundary cases:
//   - m_resp_valid outside WAIT_RESP: ignored.
//   - Holds the same when m_resp_valid coincides with new enqueues.
//   - cN_resp_rdata holds last value between pulses.
//   - Reset mid-transaction: flushes FIFOs and the in-flight request; no response is generated.
// TESTING
//  T1: c0 read A=0x0010, m_req_ready=1, resp 3 cyc later D0 -> m_req_valid at +2; c0_resp_valid 1 cyc with D0; c1 silent.
//  T2: c1 write 0x0100 then read 0x0104 on consecutive cycles -> downstream order write, read; c1 gets one resp.
//  T3: c0 and c1 reads same cycle, last_grant=0 -> c1 issued first; then c0; each resp routed to its owner.
//  T4: m_req_ready held 0 for 5 cycles -> m_req_* stable all 5 cycles; exactly one handshake counted.
//  T5: 3 c0 pushes while FSM stalled in WAIT_RESP, QDEPTH=2 -> third dropped; c0_overflow=1 until reset.
//  T6: rst_n low during WAIT_RESP -> all outputs 0 immediately; late m_resp_valid after reset produces no resp.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between two cache clients, the shared line-memory port and the arbiter.
// slave = arbiter view, master = client/memory side view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int LINE_W = 256
);
    logic              c0_req_valid;
    logic              c0_req_rw;
    logic [ADDR_W-1:0] c0_req_addr;
    logic [LINE_W-1:0] c0_req_wdata;
    logic              c0_resp_valid;
    logic [LINE_W-1:0] c0_resp_rdata;
    logic              c0_overflow;

    logic              c1_req_valid;
    logic              c1_req_rw;
    logic [ADDR_W-1:0] c1_req_addr;
    logic [LINE_W-1:0] c1_req_wdata;
    logic              c1_resp_valid;
    logic [LINE_W-1:0] c1_resp_rdata;
    logic              c1_overflow;

    logic              m_req_valid;
    logic              m_req_ready;
    logic              m_req_rw;
    logic [ADDR_W-1:0] m_req_addr;
    logic [LINE_W-1:0] m_req_wdata;
    logic              m_resp_valid;
    logic [LINE_W-1:0] m_resp_rdata;

    modport slave (
        input  c0_req_valid, c0_req_rw, c0_req_addr, c0_req_wdata,
        input  c1_req_valid, c1_req_rw, c1_req_addr, c1_req_wdata,
        output c0_resp_valid, c0_resp_rdata, c0_overflow,
        output c1_resp_valid, c1_resp_rdata, c1_overflow,
        output m_req_valid, m_req_rw, m_req_addr, m_req_wdata,
        input  m_req_ready, m_resp_valid, m_resp_rdata
    );

    modport master (
        output c0_req_valid, c0_req_rw, c0_req_addr, c0_req_wdata,
        output c1_req_valid, c1_req_rw, c1_req_addr, c1_req_wdata,
        input  c0_resp_valid, c0_resp_rdata, c0_overflow,
        input  c1_resp_valid, c1_resp_rdata, c1_overflow,
        input  m_req_valid, m_req_rw, m_req_addr, m_req_wdata,
        output m_req_ready, m_resp_valid, m_resp_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-client round-robin arbiter onto one line-memory port, one transaction in flight,
// with a small per-client request FIFO because cache requests cannot be back-pressured.
module mem_port_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   cnt;

    assign head  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by cnt.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

module mem_port_arbiter #(
    parameter int ADDR_W = 15,
    parameter int LINE_W = 256,
    parameter int QDEPTH = 2
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int ENT_W = 1 + ADDR_W + LINE_W;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;

    logic [1:0]             req_valid, push, pop, full, empty, ovf, resp_valid;
    logic [1:0][ENT_W-1:0]  din, head;
    logic [1:0][LINE_W-1:0] resp_rdata;

    logic [1:0]        state;
    logic              last_grant, owner, winner, grant;
    logic              iss_rw;
    logic [ADDR_W-1:0] iss_addr;
    logic [LINE_W-1:0] iss_wdata;

    assign req_valid = {bus.c1_req_valid, bus.c0_req_valid};
    assign din[0]    = {bus.c0_req_rw, bus.c0_req_addr, bus.c0_req_wdata};
    assign din[1]    = {bus.c1_req_rw, bus.c1_req_addr, bus.c1_req_wdata};

    for (genvar g = 0; g < 2; g++) begin : g_cl
        // A full FIFO still accepts when its head leaves in the same cycle.
        assign push[g] = req_valid[g] & (~full[g] | pop[g]);

        mem_port_req_fifo #(.W(ENT_W), .DEPTH(QDEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (din[g]),
            .head  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ovf[g] <= 1'b0;
            else if (req_valid[g] & full[g] & ~pop[g]) ovf[g] <= 1'b1;
        end
    end

    always_comb begin
        grant  = (state == IDLE) && (empty != 2'b11);
        winner = (empty == 2'b00) ? ~last_grant : empty[0];
        pop    = grant ? (2'b01 << winner) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            owner      <= 1'b0;
            iss_rw     <= 1'b0;
            iss_addr   <= '0;
            iss_wdata  <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: if (grant) begin
                    {iss_rw, iss_addr, iss_wdata} <= head[winner];
                    owner      <= winner;
                    last_grant <= winner;
                    state      <= ISSUE;
                end
                ISSUE: if (bus.m_req_ready) state <= iss_rw ? IDLE : WAIT_RESP;
                WAIT_RESP: if (bus.m_resp_valid) begin
                    resp_valid[owner] <= 1'b1;
                    resp_rdata[owner] <= bus.m_resp_rdata;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_req_valid   = (state == ISSUE);
    assign bus.m_req_rw      = iss_rw;
    assign bus.m_req_addr    = iss_addr;
    assign bus.m_req_wdata   = iss_wdata;
    assign bus.c0_resp_valid = resp_valid[0];
    assign bus.c1_resp_valid = resp_valid[1];
    assign bus.c0_resp_rdata = resp_rdata[0];
    assign bus.c1_resp_rdata = resp_rdata[1];
    assign bus.c0_overflow   = ovf[0];
    assign bus.c1_overflow   = ovf[1];
endmodule
